h_key_power_table_seq: RTL and testbench

- Sequential, resource-shared successor to the combinational GHASH hash-key power table.
- Computes H^1..H^N_BLOCKS in GF(2^128) using the GCM polynomial x^128+x^7+x^2+x+1.
- Uses one shared multiplier-plus-reduction datapath, iterating one power per enabled cycle instead of N_BLOCKS-1 parallel multipliers.
- Holds the finished table in registers and commits it atomically, so the GHASH core always sees a stable table and a valid flag.

---
 rtl/h_key_power_table_seq_pkg.sv | 27 ++
 rtl/h_key_power_table_seq_if.sv | 28 ++
 rtl/h_key_power_table_seq_gf128_mult_reduce.sv | 37 +++
 rtl/h_key_power_table_seq.sv | 126 ++++++++++++
 tb/tb_h_key_power_table_seq.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/h_key_power_table_seq_pkg.sv
// Shared constants and types for the sequential GHASH key power table.
`ifndef H_KEY_POWER_TABLE_SEQ_PKG_SV
`define H_KEY_POWER_TABLE_SEQ_PKG_SV

// Elaboration stops with a message when cond is false.
`define HKP_CFG_CHECK(cond, msg) \
  if (!(cond)) begin : g_bad_cfg \
    $error(msg); \
  end

package h_key_power_table_seq_pkg;

  localparam int NB_BLOCK_GCM = 128;

  // x^128+x^7+x^2+x+1, reflected: bit 127 is x^0
  localparam logic [NB_BLOCK_GCM-1:0] GCM_POLY =
    {8'hE1, 120'h0};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

`endif

// File: rtl/h_key_power_table_seq_if.sv
// Load/enable inputs and committed-table outputs
// of the key power table.
interface h_key_power_table_seq_if
  import h_key_power_table_seq_pkg::*;
#(
  parameter int N_BLOCKS = 8,
  parameter int NB_DATA  = NB_BLOCK_GCM * N_BLOCKS
);
  logic [NB_BLOCK_GCM-1:0] i_h_key;
  logic                    i_load;
  logic                    i_valid;
  logic [NB_DATA-1:0]      o_h_key_powers;
  logic                    o_table_valid;
  logic                    o_busy;
  logic                    o_done;

  modport master (
    output i_h_key, i_load, i_valid,
    input  o_h_key_powers, o_table_valid,
    input  o_busy, o_done
  );

  modport slave (
    input  i_h_key, i_load, i_valid,
    output o_h_key_powers, o_table_valid,
    output o_busy, o_done
  );
endinterface

// File: rtl/h_key_power_table_seq_gf128_mult_reduce.sv
// Single-stage GF(2^128) multiply: carry-less product
// followed by a bit-serial remainder fold.
module gf128_mult_reduce
  import h_key_power_table_seq_pkg::*;
(
  input  logic [NB_BLOCK_GCM-1:0] i_a,
  input  logic [NB_BLOCK_GCM-1:0] i_b,
  output logic [NB_BLOCK_GCM-1:0] o_p
);
  localparam int NP = 2 * NB_BLOCK_GCM - 1;
  // reflected: degree d sits at bit NP-1-d
  localparam logic [NP-1:0] RED = NP'(GCM_POLY) << 1;

  logic [NP-1:0] w_prod;
  logic [NP-1:0] w_rem;

  always_comb begin
    w_prod = '0;
    for (int i = 0; i < NB_BLOCK_GCM; i++) begin
      if (i_a[7'(NB_BLOCK_GCM - 1 - i)]) begin
        w_prod = w_prod ^ ({i_b, 127'b0} >> i);
      end
    end
  end

  // fold degrees 254..128 from the top down
  always_comb begin
    w_rem = w_prod;
    for (int k = 0; k < NB_BLOCK_GCM - 1; k++) begin
      if (w_rem[k[7:0]]) begin
        w_rem = w_rem ^ (RED << k);
      end
    end
  end

  assign o_p = w_rem[NP-1:NB_BLOCK_GCM-1];
endmodule

// File: rtl/h_key_power_table_seq.sv
// Sequential GHASH hash-key power table: H^1..H^N over one
// shared GF(2^128) multiplier, committed atomically.
module h_key_power_table_seq
  import h_key_power_table_seq_pkg::*;
#(
  parameter int NB_BLOCK = 128,
  parameter int N_BLOCKS = 8,
  parameter int NB_DATA  = NB_BLOCK * N_BLOCKS,
  parameter int NB_IDX   = 6
) (
  input logic                   i_clock,
  input logic                   i_reset_n,
  h_key_power_table_seq_if.slave bus
);
  `HKP_CFG_CHECK((NB_BLOCK == NB_BLOCK_GCM) &&
                 (N_BLOCKS >= 1) && (N_BLOCKS <= 64) &&
                 ((1 << NB_IDX) >= N_BLOCKS),
                 "h_key_power_table_seq: bad configuration")

  localparam logic [NB_IDX-1:0] LAST = NB_IDX'(N_BLOCKS - 1);

  state_e              r_state;
  state_e              w_next;
  logic [NB_IDX-1:0]   r_idx;
  logic [NB_BLOCK-1:0] r_key;
  logic [NB_BLOCK-1:0] r_work [N_BLOCKS];
  logic [NB_DATA-1:0]  r_table;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                w_mul;
  logic                w_commit;
  logic [NB_BLOCK-1:0] w_prev;
  logic [NB_BLOCK-1:0] w_prod;
  logic [NB_DATA-1:0]  w_pack;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  // a new load always wins, even over a pending commit
  always_comb begin
    w_next   = r_state;
    w_mul    = 1'b0;
    w_commit = 1'b0;
    if (bus.i_load) begin
      w_next = (N_BLOCKS == 1) ? ST_COMMIT : ST_CALC;
    end else begin
      unique case (r_state)
        ST_CALC: begin
          if (bus.i_valid) begin
            w_mul = 1'b1;
            if (r_idx == LAST) w_next = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          w_commit = 1'b1;
          w_next   = ST_IDLE;
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_prev = '0;
    for (int i = 0; i < N_BLOCKS - 1; i++) begin
      if (r_idx == NB_IDX'(i + 1)) w_prev = r_work[i];
    end
  end

  gf128_mult_reduce u_mul (
    .i_a (w_prev),
    .i_b (r_key),
    .o_p (w_prod)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_idx <= '0;
      r_key <= '0;
      for (int i = 0; i < N_BLOCKS; i++) r_work[i] <= '0;
    end else if (bus.i_load) begin
      r_idx     <= NB_IDX'(1);
      r_key     <= bus.i_h_key;
      r_work[0] <= bus.i_h_key;
    end else if (w_mul) begin
      r_idx <= r_idx + NB_IDX'(1);
      for (int i = 1; i < N_BLOCKS; i++) begin
        if (r_idx == NB_IDX'(i)) r_work[i] <= w_prod;
      end
    end
  end

  always_comb begin
    w_pack = '0;
    for (int i = 0; i < N_BLOCKS; i++) begin
      w_pack[i*NB_BLOCK +: NB_BLOCK] = r_work[i];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_table <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (bus.i_load) begin
        r_valid <= 1'b0;
        r_busy  <= 1'b1;
      end else if (w_commit) begin
        r_table <= w_pack;
        r_valid <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  assign bus.o_h_key_powers = r_table;
  assign bus.o_table_valid  = r_valid;
  assign bus.o_busy         = r_busy;
  assign bus.o_done         = r_done;
endmodule

// File: tb/tb_h_key_power_table_seq.sv
// Scoreboard bench for the sequential key power table:
// stimulus queues expected commits, a monitor checks each o_done.
module tb_h_key_power_table_seq;
  localparam int NB = 128;
  localparam int NBLK = 8;
  localparam int ND = NB * NBLK;

  localparam logic [NB-1:0] ONE  = {1'b1, 127'b0};
  localparam logic [NB-1:0] HN   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [NB-1:0] HA   = 128'hfeedfacedeadbeef0123456789abcdef;

  typedef struct {
    logic [ND-1:0] tbl;
    int            cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  exp_t sb[$];

  h_key_power_table_seq_if #(.N_BLOCKS(NBLK)) bus ();

  h_key_power_table_seq #(.N_BLOCKS(NBLK)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  // bit-serial reference multiply (GCM shift-and-add form)
  function automatic logic [NB-1:0] gf_mul_ref(
    input logic [NB-1:0] x, input logic [NB-1:0] y);
    logic [NB-1:0] z;
    logic [NB-1:0] v;
    z = '0;
    v = y;
    for (int i = 0; i < NB; i++) begin
      if (x[7'(NB - 1 - i)]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'hE1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [ND-1:0] build_table(input logic [NB-1:0] h);
    logic [ND-1:0] t;
    logic [NB-1:0] p;
    p = h;
    t = '0;
    t[0 +: NB] = h;
    for (int i = 1; i < NBLK; i++) begin
      p = gf_mul_ref(p, h);
      t[i*NB +: NB] = p;
    end
    return t;
  endfunction

  task automatic chk(input string name, input logic [NB-1:0] got,
                     input logic [NB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_tbl(input string name, input logic [ND-1:0] got,
                         input logic [ND-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      for (int i = 0; i < NBLK; i++) begin
        if (got[i*NB +: NB] !== exp[i*NB +: NB])
          $display("FAIL %s slice%0d got=%h exp=%h", name, i,
                   got[i*NB +: NB], exp[i*NB +: NB]);
      end
    end
  endtask

  // monitor: every o_done must match the oldest queued commit
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=1 exp=0 at cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        chk_tbl("done_table", bus.o_h_key_powers, e.tbl);
        chk("done_cycle", NB'(cyc), NB'(e.cyc));
        chk("done_valid", NB'(bus.o_table_valid), NB'(1));
      end
    end
  end

  task automatic do_load(input logic [NB-1:0] h, output int e);
    @(negedge clk);
    bus.i_h_key = h;
    bus.i_load  = 1'b1;
    @(negedge clk);
    bus.i_load  = 1'b0;
    e = cyc;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, NB'(sb.size()), NB'(0));
    sb.delete();
  endtask

  task automatic run_plain(input string name, input logic [NB-1:0] h,
                           input logic [ND-1:0] exp_tbl);
    int e;
    exp_t x;
    bus.i_valid = 1'b1;
    do_load(h, e);
    x.tbl = exp_tbl;
    x.cyc = e + NBLK;
    sb.push_back(x);
    for (int k = 0; k < NBLK; k++) begin
      chk({name, "_busy"}, NB'(bus.o_busy), NB'(1));
      @(negedge clk);
    end
    chk({name, "_busy_end"}, NB'(bus.o_busy), NB'(0));
    chk({name, "_valid_end"}, NB'(bus.o_table_valid), NB'(1));
    wait_drain({name, "_drain"}, 20);
    repeat (4) @(negedge clk);
    chk({name, "_valid_hold"}, NB'(bus.o_table_valid), NB'(1));
  endtask

  initial begin
    int e;
    exp_t x;
    logic [ND-1:0] t_one;
    logic [ND-1:0] t_nist;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.i_h_key = '0;
    bus.i_load  = 1'b0;
    bus.i_valid = 1'b0;
    t_one  = {NBLK{ONE}};
    t_nist = build_table(HN);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_tbl("rst_table", bus.o_h_key_powers, '0);
    repeat (20) @(negedge clk);
    chk("idle_valid", NB'(bus.o_table_valid), NB'(0));
    chk("idle_busy", NB'(bus.o_busy), NB'(0));
    chk_tbl("idle_table", bus.o_h_key_powers, '0);

    run_plain("ident", ONE, t_one);
    run_plain("nist", HN, t_nist);
    chk("nist_h1", bus.o_h_key_powers[NB-1:0], HN);

    // stall: i_valid alternates 1/0 starting on the first CALC edge
    bus.i_valid = 1'b1;
    do_load(HN, e);
    x.tbl = t_nist;
    x.cyc = e + 14;
    sb.push_back(x);
    for (int k = 1; k <= 14; k++) begin
      bus.i_valid = k[0];
      @(negedge clk);
    end
    bus.i_valid = 1'b1;
    wait_drain("stall_drain", 20);

    // reload mid-compute: A abandoned, second load commits
    do_load(HA, e);
    repeat (2) @(negedge clk);
    do_load(ONE, e);
    x.tbl = t_one;
    x.cyc = e + NBLK;
    sb.push_back(x);
    for (int k = 0; k < NBLK - 1; k++) begin
      chk_tbl("reload_hold", bus.o_h_key_powers, t_nist);
      @(negedge clk);
    end
    chk("reload_stale", NB'(bus.o_table_valid), NB'(0));
    wait_drain("reload_drain", 20);
    repeat (8) @(negedge clk);
    chk_tbl("reload_final", bus.o_h_key_powers, t_one);

    // async reset at idx=3, between clock edges
    do_load(HN, e);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_tbl("arst_table", bus.o_h_key_powers, '0);
    chk("arst_valid", NB'(bus.o_table_valid), NB'(0));
    chk("arst_busy", NB'(bus.o_busy), NB'(0));
    chk("arst_done", NB'(bus.o_done), NB'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("arst_post_busy", NB'(bus.o_busy), NB'(0));
    chk("arst_post_valid", NB'(bus.o_table_valid), NB'(0));

    wait_drain("final_drain", 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
